// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle CPU controller and ALU.
// Defining CPU_CTRL_ILLEGAL_TRAP_EN adds the TRAP state to ctrl_state_t.
package cpu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_opcode_t;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
        ,
        S_TRAP     = 4'd11
`endif
    } ctrl_state_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_IALU  = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_RD1   = 2'b10;

    localparam logic [1:0] SRC_B_IMM  = 2'b00;
    localparam logic [1:0] SRC_B_RD2  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_MEMDATA   = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // ALU operation class handed from the FSM to the funct decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/cpu_alu_decoder.sv
// Combinational ALU decoder: maps the FSM's operation class plus funct
// fields to the cpu_alu op_sel encoding.
module cpu_alu_decoder
    import cpu_pkg::*;
(
    input  logic [1:0]  alu_op,
    input  logic [2:0]  funct3,
    input  logic        funct7_b5,
    input  logic        opcode_b5,
    output alu_opcode_t alu_op_sel
);

    always_comb begin
        alu_op_sel = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_op_sel = ALU_ADD;
            ALUOP_SUB: alu_op_sel = ALU_SUB;
            ALUOP_FUNCT: begin
                // opcode_b5 separates R-type from I-ALU; addi has no subtract form
                case (funct3)
                    3'b000:  alu_op_sel = (opcode_b5 && funct7_b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_op_sel = ALU_SLT;
                    3'b110:  alu_op_sel = ALU_OR;
                    3'b111:  alu_op_sel = ALU_AND;
                    default: alu_op_sel = ALU_ADD;
                endcase
            end
            default: alu_op_sel = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle main controller: sequences Fetch/Decode/Execute/Memory/Writeback.
// Define CPU_CTRL_ILLEGAL_TRAP_EN to trap unsupported opcodes in a sticky TRAP state.
module cpu_control_fsm
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_b5,
    input  logic       z_flag,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op_sel,
    output logic       reg_write,
    output logic       illegal_instr
);

    ctrl_state_t state_q;
    ctrl_state_t state_d;
    ctrl_state_t dec_state;
    logic        pc_update;
    logic        branch;
    logic        ir_write_en;
    logic        mem_write_en;
    logic        reg_write_en;
    logic [1:0]  alu_op;
    alu_opcode_t alu_sel;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTER;
                    OP_IALU:      state_d = S_EXECUTEI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
                    default:      state_d = S_TRAP;
`else
                    default:      state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   state_d = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = S_FETCH;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
            S_TRAP:     state_d = S_TRAP;
`endif
            default:    state_d = S_FETCH;
        endcase
    end

    // While reset is held the muxes show the FETCH decode so the datapath is
    // already steered for the first fetch; the enables are masked below.
    always_comb begin
        dec_state = rst_n ? state_q : S_FETCH;
    end

    always_comb begin
        pc_update    = 1'b0;
        branch       = 1'b0;
        ir_write_en  = 1'b0;
        mem_write_en = 1'b0;
        reg_write_en = 1'b0;
        adr_src      = 1'b0;
        result_src   = RES_ALUOUT;
        alu_src_a    = SRC_A_PC;
        alu_src_b    = SRC_B_IMM;
        alu_op       = ALUOP_ADD;
        case (dec_state)
            S_FETCH: begin
                ir_write_en = 1'b1;
                pc_update   = 1'b1;
                alu_src_b   = SRC_B_FOUR;
                result_src  = RES_ALURESULT;
            end
            S_DECODE: begin
                alu_src_a = SRC_A_OLDPC;
            end
            S_MEMADR: begin
                alu_src_a = SRC_A_RD1;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                result_src   = RES_MEMDATA;
                reg_write_en = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src      = 1'b1;
                mem_write_en = 1'b1;
            end
            S_EXECUTER: begin
                alu_src_a = SRC_A_RD1;
                alu_src_b = SRC_B_RD2;
                alu_op    = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                alu_src_a = SRC_A_RD1;
                alu_src_b = SRC_B_IMM;
                alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                reg_write_en = 1'b1;
            end
            S_BEQ: begin
                alu_src_a = SRC_A_RD1;
                alu_src_b = SRC_B_RD2;
                alu_op    = ALUOP_SUB;
                branch    = 1'b1;
            end
            S_JAL: begin
                alu_src_a = SRC_A_OLDPC;
                alu_src_b = SRC_B_FOUR;
                pc_update = 1'b1;
            end
            default: begin
            end
        endcase
    end

    cpu_alu_decoder u_alu_decoder (
        .alu_op     (alu_op),
        .funct3     (funct3),
        .funct7_b5  (funct7_b5),
        .opcode_b5  (opcode[5]),
        .alu_op_sel (alu_sel)
    );

    assign alu_op_sel = alu_sel;

    // z_flag is used combinationally so the branch resolves in the BEQ cycle
    assign pc_write  = rst_n & (pc_update | (branch & z_flag));
    assign ir_write  = rst_n & ir_write_en;
    assign mem_write = rst_n & mem_write_en;
    assign reg_write = rst_n & reg_write_en;

`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
    assign illegal_instr = (dec_state == S_TRAP);
`else
    assign illegal_instr = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Table-driven testbench for cpu_control_fsm, with hand-written sequences for
// reset abort, mid-cycle z_flag change and the illegal-opcode path.
module tb_cpu_control_fsm;

    localparam logic [6:0] OPC_LW    = 7'b0000011;
    localparam logic [6:0] OPC_SW    = 7'b0100011;
    localparam logic [6:0] OPC_RTYPE = 7'b0110011;
    localparam logic [6:0] OPC_IALU  = 7'b0010011;
    localparam logic [6:0] OPC_BEQ   = 7'b1100011;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_ILL   = 7'b1111111;

    logic       clk;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_b5;
    logic       z_flag;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op_sel;
    logic       reg_write;
    logic       illegal_instr;

    int errors;
    int checks;

    typedef struct {
        string       name;
        logic        rst_n;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic        funct7_b5;
        logic        z_flag;
        logic [14:0] exp;
    } vec_t;

    vec_t vecs[$];

    cpu_control_fsm dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .funct3        (funct3),
        .funct7_b5     (funct7_b5),
        .z_flag        (z_flag),
        .pc_write      (pc_write),
        .adr_src       (adr_src),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .result_src    (result_src),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op_sel    (alu_op_sel),
        .reg_write     (reg_write),
        .illegal_instr (illegal_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output word: {pcw, adr, memw, irw, result_src, src_a, src_b, op, regw, illegal}
    function automatic logic [14:0] outs(input logic pcw, input logic adr, input logic mw,
                                         input logic irw, input logic [1:0] rs,
                                         input logic [1:0] sa, input logic [1:0] sb,
                                         input logic [2:0] op, input logic rw, input logic ill);
        return {pcw, adr, mw, irw, rs, sa, sb, op, rw, ill};
    endfunction

    function automatic logic [14:0] e_reset();    return outs(0,0,0,0,2'b10,2'b00,2'b10,3'b000,0,0); endfunction
    function automatic logic [14:0] e_fetch();    return outs(1,0,0,1,2'b10,2'b00,2'b10,3'b000,0,0); endfunction
    function automatic logic [14:0] e_decode();   return outs(0,0,0,0,2'b00,2'b01,2'b00,3'b000,0,0); endfunction
    function automatic logic [14:0] e_memadr();   return outs(0,0,0,0,2'b00,2'b10,2'b00,3'b000,0,0); endfunction
    function automatic logic [14:0] e_memread();  return outs(0,1,0,0,2'b00,2'b00,2'b00,3'b000,0,0); endfunction
    function automatic logic [14:0] e_memwb();    return outs(0,0,0,0,2'b01,2'b00,2'b00,3'b000,1,0); endfunction
    function automatic logic [14:0] e_memwrite(); return outs(0,1,1,0,2'b00,2'b00,2'b00,3'b000,0,0); endfunction
    function automatic logic [14:0] e_aluwb();    return outs(0,0,0,0,2'b00,2'b00,2'b00,3'b000,1,0); endfunction
    function automatic logic [14:0] e_jal();      return outs(1,0,0,0,2'b00,2'b01,2'b10,3'b000,0,0); endfunction
    function automatic logic [14:0] e_trap();     return outs(0,0,0,0,2'b00,2'b00,2'b00,3'b000,0,1); endfunction
    function automatic logic [14:0] e_execr(input logic [2:0] op); return outs(0,0,0,0,2'b00,2'b10,2'b01,op,0,0); endfunction
    function automatic logic [14:0] e_execi(input logic [2:0] op); return outs(0,0,0,0,2'b00,2'b10,2'b00,op,0,0); endfunction
    function automatic logic [14:0] e_beq(input logic z);          return outs(z,0,0,0,2'b00,2'b10,2'b01,3'b001,0,0); endfunction

    task automatic add_vec(input string name, input logic rst, input logic [6:0] opc,
                           input logic [2:0] f3, input logic f7, input logic z,
                           input logic [14:0] exp);
        vec_t v;
        v.name = name; v.rst_n = rst; v.opcode = opc; v.funct3 = f3;
        v.funct7_b5 = f7; v.z_flag = z; v.exp = exp;
        vecs.push_back(v);
    endtask

    // Drive one cycle's inputs just after the rising edge, return at the falling edge
    task automatic applyStimulus(input logic rst, input logic [6:0] opc, input logic [2:0] f3,
                                 input logic f7, input logic z);
        @(posedge clk);
        #1;
        rst_n     = rst;
        opcode    = opc;
        funct3    = f3;
        funct7_b5 = f7;
        z_flag    = z;
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [14:0] exp);
        logic [14:0] act;
        act = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
               alu_op_sel, reg_write, illegal_instr};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        rst_n     = 1'b0;
        opcode    = OPC_LW;
        funct3    = 3'b000;
        funct7_b5 = 1'b0;
        z_flag    = 1'b0;

        add_vec("reset cycle 0",    0, OPC_LW, 3'b000, 0, 0, e_reset());
        add_vec("reset cycle 1",    0, OPC_LW, 3'b000, 0, 1, e_reset());
        add_vec("lw fetch",         1, OPC_LW, 3'b000, 0, 0, e_fetch());
        add_vec("lw decode",        1, OPC_LW, 3'b000, 0, 0, e_decode());
        add_vec("lw memadr",        1, OPC_LW, 3'b000, 0, 0, e_memadr());
        add_vec("lw memread",       1, OPC_LW, 3'b000, 0, 0, e_memread());
        add_vec("lw memwb",         1, OPC_LW, 3'b000, 0, 0, e_memwb());
        add_vec("sub fetch",        1, OPC_RTYPE, 3'b000, 1, 0, e_fetch());
        add_vec("sub decode",       1, OPC_RTYPE, 3'b000, 1, 0, e_decode());
        add_vec("sub executer",     1, OPC_RTYPE, 3'b000, 1, 0, e_execr(3'b001));
        add_vec("sub aluwb",        1, OPC_RTYPE, 3'b000, 1, 0, e_aluwb());
        add_vec("addi fetch",       1, OPC_IALU, 3'b000, 1, 0, e_fetch());
        add_vec("addi decode",      1, OPC_IALU, 3'b000, 1, 0, e_decode());
        add_vec("addi f7 ignored",  1, OPC_IALU, 3'b000, 1, 0, e_execi(3'b000));
        add_vec("addi aluwb",       1, OPC_IALU, 3'b000, 1, 0, e_aluwb());
        add_vec("slt fetch",        1, OPC_RTYPE, 3'b010, 0, 0, e_fetch());
        add_vec("slt decode",       1, OPC_RTYPE, 3'b010, 0, 0, e_decode());
        add_vec("slt executer",     1, OPC_RTYPE, 3'b010, 0, 0, e_execr(3'b101));
        add_vec("slt aluwb",        1, OPC_RTYPE, 3'b010, 0, 0, e_aluwb());
        add_vec("ori fetch",        1, OPC_IALU, 3'b110, 0, 0, e_fetch());
        add_vec("ori decode",       1, OPC_IALU, 3'b110, 0, 0, e_decode());
        add_vec("ori executei",     1, OPC_IALU, 3'b110, 0, 0, e_execi(3'b011));
        add_vec("ori aluwb",        1, OPC_IALU, 3'b110, 0, 0, e_aluwb());
        add_vec("and fetch",        1, OPC_RTYPE, 3'b111, 1, 0, e_fetch());
        add_vec("and decode",       1, OPC_RTYPE, 3'b111, 1, 0, e_decode());
        add_vec("and executer",     1, OPC_RTYPE, 3'b111, 1, 0, e_execr(3'b010));
        add_vec("and aluwb",        1, OPC_RTYPE, 3'b111, 1, 0, e_aluwb());
        add_vec("beq taken fetch",  1, OPC_BEQ, 3'b000, 0, 1, e_fetch());
        add_vec("beq taken decode", 1, OPC_BEQ, 3'b000, 0, 1, e_decode());
        add_vec("beq taken",        1, OPC_BEQ, 3'b000, 0, 1, e_beq(1'b1));
        add_vec("beq nt fetch",     1, OPC_BEQ, 3'b000, 0, 0, e_fetch());
        add_vec("beq nt decode",    1, OPC_BEQ, 3'b000, 0, 0, e_decode());
        add_vec("beq not taken",    1, OPC_BEQ, 3'b000, 0, 0, e_beq(1'b0));
        add_vec("jal fetch",        1, OPC_JAL, 3'b000, 0, 1, e_fetch());
        add_vec("jal decode",       1, OPC_JAL, 3'b000, 0, 1, e_decode());
        add_vec("jal jal",          1, OPC_JAL, 3'b000, 0, 1, e_jal());
        add_vec("jal aluwb",        1, OPC_JAL, 3'b000, 0, 1, e_aluwb());
        add_vec("sw fetch",         1, OPC_SW, 3'b010, 0, 0, e_fetch());
        add_vec("sw decode",        1, OPC_SW, 3'b010, 0, 0, e_decode());
        add_vec("sw memadr",        1, OPC_SW, 3'b010, 0, 0, e_memadr());
        add_vec("sw memwrite",      1, OPC_SW, 3'b010, 0, 0, e_memwrite());
        add_vec("f3=001 fetch",     1, OPC_RTYPE, 3'b001, 1, 0, e_fetch());
        add_vec("f3=001 decode",    1, OPC_RTYPE, 3'b001, 1, 0, e_decode());
        add_vec("f3=001 add",       1, OPC_RTYPE, 3'b001, 1, 0, e_execr(3'b000));
        add_vec("f3=001 aluwb",     1, OPC_RTYPE, 3'b001, 1, 0, e_aluwb());
        add_vec("illegal fetch",    1, OPC_ILL, 3'b000, 0, 0, e_fetch());
        add_vec("illegal decode",   1, OPC_ILL, 3'b000, 0, 0, e_decode());
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
        add_vec("illegal trap",     1, OPC_ILL, 3'b000, 0, 0, e_trap());
`else
        add_vec("illegal nop",      1, OPC_ILL, 3'b000, 0, 0, e_fetch());
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst_n, vecs[i].opcode, vecs[i].funct3,
                          vecs[i].funct7_b5, vecs[i].z_flag);
            checkOutput(vecs[i].name, vecs[i].exp);
        end

`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
        // TRAP must ignore new opcodes and z_flag until reset
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1, OPC_LW, 3'b000, 0, 1);
            checkOutput($sformatf("trap hold %0d", k), e_trap());
        end
`endif
        applyStimulus(0, OPC_LW, 3'b000, 0, 0);
        checkOutput("reset after illegal", e_reset());
        applyStimulus(1, OPC_LW, 3'b000, 0, 0);
        checkOutput("fetch after illegal reset", e_fetch());

        // Reset asserted while sitting in MEMWRITE must suppress the store
        applyStimulus(1, OPC_SW, 3'b000, 0, 0);
        checkOutput("sw2 decode", e_decode());
        applyStimulus(1, OPC_SW, 3'b000, 0, 0);
        checkOutput("sw2 memadr", e_memadr());
        applyStimulus(0, OPC_SW, 3'b000, 0, 0);
        checkOutput("sw2 reset in memwrite", e_reset());
        applyStimulus(1, OPC_SW, 3'b000, 0, 0);
        checkOutput("sw2 fetch after abort", e_fetch());

        // z_flag rising inside the BEQ cycle must raise pc_write immediately
        applyStimulus(1, OPC_BEQ, 3'b000, 0, 0);
        checkOutput("beq2 decode", e_decode());
        applyStimulus(1, OPC_BEQ, 3'b000, 0, 0);
        checkOutput("beq2 z low", e_beq(1'b0));
        #1;
        z_flag = 1'b1;
        #1;
        checkOutput("beq2 z rises mid-cycle", e_beq(1'b1));
        applyStimulus(1, OPC_LW, 3'b000, 0, 1);
        checkOutput("beq2 fetch after", e_fetch());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
